snn_layer_sequencer: RTL and testbench

Time-multiplexed controller for one fully connected layer of leaky integrate-and-fire neurons. It sequences a single shared accumulate/LIF-update datapath over all post-synaptic neurons once per timestep. Membrane potentials and the weight matrix live in internal registers, and a configuration port programs the weights. It replaces one-instance-per-neuron fan-in when area matters more than latency, and sits between the input spike source and the next layer's spike inputs.

---
 rtl/snn_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_snn_layer_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_layer_sequencer.sv
// Time-multiplexed LIF layer: one shared accumulate/update datapath walks all post neurons per timestep.
// Latency: done N_POST*(N_PRE+1)+1 cycles after start acceptance; start is ignored while busy (not queued).
module snn_layer_sequencer #(
  parameter int V_SIZE = 8,
  parameter int N_PRE  = 3,
  parameter int N_POST = 3,
  parameter int THRESH = 8,
  parameter int LEAK   = 1,
  parameter int AW     = $clog2(N_PRE*N_POST)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [N_PRE-1:0]  spike_in,
  output logic              busy,
  output logic              done,
  output logic [N_POST-1:0] spike_out,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [V_SIZE-1:0] cfg_wdata
);

  localparam int NW = N_PRE * N_POST;
  localparam int IW = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam int JW = (N_POST > 1) ? $clog2(N_POST) : 1;
  localparam logic [V_SIZE-1:0] VMAX = '1;
  localparam logic [V_SIZE-1:0] THR  = V_SIZE'(THRESH);
  localparam logic [V_SIZE-1:0] LK   = V_SIZE'(LEAK);
  localparam logic [IW-1:0] I_LAST = IW'(N_PRE - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_POST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t              state;
  logic [V_SIZE-1:0]   w [0:NW-1];
  logic [V_SIZE-1:0]   v [0:N_POST-1];
  logic [N_PRE-1:0]    spike_q;
  logic [N_POST-1:0]   spike_nxt;
  logic [IW-1:0]       i;
  logic [JW-1:0]       j;
  logic [V_SIZE-1:0]   acc;

  logic [AW-1:0]       widx;
  logic [V_SIZE-1:0]   w_sel;
  logic [V_SIZE:0]     acc_sum;
  logic [V_SIZE-1:0]   acc_nxt;
  logic [V_SIZE:0]     v_sum_w;
  logic [V_SIZE-1:0]   vsum;
  logic [V_SIZE-1:0]   v_leak;
  logic                fire;
  logic [N_POST-1:0]   spike_fin;
  logic                cfg_ok;

  assign widx   = AW'(int'(j) * N_PRE + int'(i));
  assign cfg_ok = cfg_we && (int'(cfg_addr) < NW);

  // Both additions saturate; leak floors at zero instead of wrapping.
  always_comb begin
    w_sel     = spike_q[i] ? w[widx] : '0;
    acc_sum   = {1'b0, acc} + {1'b0, w_sel};
    acc_nxt   = acc_sum[V_SIZE] ? VMAX : acc_sum[V_SIZE-1:0];
    v_sum_w   = {1'b0, v[j]} + {1'b0, acc};
    vsum      = v_sum_w[V_SIZE] ? VMAX : v_sum_w[V_SIZE-1:0];
    fire      = (vsum >= THR);
    v_leak    = (vsum > LK) ? (vsum - LK) : '0;
    spike_fin = spike_nxt;
    spike_fin[j] = fire;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      spike_out <= '0;
      spike_q   <= '0;
      spike_nxt <= '0;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
      for (int k = 0; k < NW; k++) w[k] <= '0;
      for (int k = 0; k < N_POST; k++) v[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_ok) w[cfg_addr] <= cfg_wdata;
          if (start) begin
            spike_q <= spike_in;
            i       <= '0;
            j       <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc_nxt;
          if (i == I_LAST) state <= S_UPDATE;
          else             i     <= i + 1'b1;
        end
        S_UPDATE: begin
          spike_nxt[j] <= fire;
          v[j]         <= fire ? '0 : v_leak;
          // spike_out is loaded on the edge into DONE so it is already new while done is high.
          if (j == J_LAST) begin
            spike_out <= spike_fin;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            j     <= j + 1'b1;
            i     <= '0;
            acc   <= '0;
            state <= S_ACCUM;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Randomized bench for snn_layer_sequencer: a timestep-level reference model feeds a scoreboard
// queue that an independent monitor drains whenever done pulses.
module tb_snn_layer_sequencer;

  localparam int NPRE = 3;
  localparam int NPOST = 3;
  localparam int NW = 9;
  localparam int LAT = 13;
  localparam int PERIOD = 14;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [2:0] spike_in = '0;
  logic       busy;
  logic       done;
  logic [2:0] spike_out;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;

  snn_layer_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .spike_in  (spike_in),
    .busy      (busy),
    .done      (done),
    .spike_out (spike_out),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [2:0]     sp;
    logic [2:0][7:0] v;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: weights, membranes and the model's view of when the DUT is free.
  int         wm [NW];
  int         vm [NPOST];
  int         free_cyc = 0;
  int         busy_from = -10;
  int         busy_until = -10;
  logic [2:0] last_sp = '0;

  task automatic model_reset();
    for (int k = 0; k < NW; k++) wm[k] = 0;
    for (int k = 0; k < NPOST; k++) vm[k] = 0;
    q.delete();
    free_cyc   = 0;
    busy_from  = -10;
    busy_until = -10;
    last_sp    = '0;
  endtask

  // One timestep at the level of the LIF equations.
  task automatic model_timestep(input logic [2:0] sp, input int c);
    exp_t e;
    e.sp = '0;
    for (int j = 0; j < NPOST; j++) begin
      int a, s;
      a = 0;
      for (int i = 0; i < NPRE; i++) if (sp[i]) a += wm[j*NPRE + i];
      if (a > 255) a = 255;
      s = vm[j] + a;
      if (s > 255) s = 255;
      if (s >= 8) begin
        e.sp[j] = 1'b1;
        vm[j] = 0;
      end else begin
        vm[j] = (s > 1) ? s - 1 : 0;
      end
      e.v[j] = 8'(vm[j]);
    end
    e.cyc = c + LAT;
    q.push_back(e);
    busy_from  = c + 1;
    busy_until = c + LAT;
    free_cyc   = c + PERIOD;
  endtask

  task automatic drive(input logic st, input logic [2:0] sp, input logic we,
                       input logic [3:0] a, input logic [7:0] d);
    bit idle;
    @(negedge clk);
    start = st; spike_in = sp; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    idle = (cyc >= free_cyc);
    if (idle && we && a < NW) wm[a] = d;
    if (idle && st) model_timestep(sp, cyc);
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || spike_out !== 3'b000) begin
      fails++;
      $display("FAIL %s: busy=%b done=%b spike_out=%b, required 0 0 000", name, busy, done, spike_out);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rstn = 1'b0; start = 1'b0; cfg_we = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(name);
    repeat (2) @(negedge clk);
    check_reset_outputs({name, "_held"});
    rstn = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < free_cyc || q.size() > 0) && n < 200) begin
      drive(1'b0, 3'($urandom), 1'b0, 4'd0, 8'd0);
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL idle_timeout: pending=%0d after %0d cycles, required 0", q.size(), n);
      q.delete();
    end
  endtask

  task automatic write_w(input int a, input int d);
    drive(1'b0, 3'b000, 1'b1, 4'(a), 8'(d));
  endtask

  task automatic step(input logic [2:0] sp);
    drive(1'b1, sp, 1'b0, 4'd0, 8'd0);
    wait_idle();
  endtask

  // Monitor: busy window, spike_out stability, and done-time scoreboard.
  exp_t e_m;
  logic exp_busy;
  always @(negedge clk) begin
    if (rstn) begin
      exp_busy = (cyc >= busy_from) && (cyc <= busy_until);
      tests++;
      if (busy !== exp_busy) begin
        fails++;
        $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, exp_busy);
      end
      if (done === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done cyc=%0d: got done=1, required 0", cyc);
        end else begin
          e_m = q.pop_front();
          if (cyc != e_m.cyc || spike_out !== e_m.sp) begin
            fails++;
            $display("FAIL done_result: cyc=%0d spike_out=%b, required cyc=%0d spike_out=%b",
                     cyc, spike_out, e_m.cyc, e_m.sp);
          end
          for (int k = 0; k < NPOST; k++) begin
            tests++;
            if (dut.v[k] !== e_m.v[k]) begin
              fails++;
              $display("FAIL membrane[%0d] cyc=%0d: got %0d, required %0d", k, cyc, dut.v[k], e_m.v[k]);
            end
          end
          last_sp = e_m.sp;
        end
      end else begin
        tests++;
        if (spike_out !== last_sp) begin
          fails++;
          $display("FAIL spike_out_hold cyc=%0d: got %b, required %b", cyc, spike_out, last_sp);
        end
        if (q.size() > 0 && cyc > q[0].cyc) begin
          tests++; fails++;
          $display("FAIL missing_done: cyc=%0d, required done at cyc=%0d", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int wtab [NW];
    wtab = '{3, 3, 2, 1, 2, 3, 4, 3, 4};

    do_reset("reset_initial");
    step(3'b111);

    // Abort mid-accumulation, then rerun with cleared weights.
    drive(1'b1, 3'b111, 1'b0, 4'd0, 8'd0);
    repeat (3) drive(1'b0, 3'b000, 1'b0, 4'd0, 8'd0);
    do_reset("reset_mid_accum");
    step(3'b111);

    // Two timesteps with programmed weights.
    for (int k = 0; k < NW; k++) write_w(k, wtab[k]);
    step(3'b111);
    step(3'b111);

    // Leak and floor on neuron 1.
    step(3'b100);
    step(3'b001);
    repeat (3) step(3'b000);

    // Saturation.
    for (int k = 0; k < NW; k++) write_w(k, 255);
    step(3'b111);
    step(3'b011);

    // Disturbances while busy plus out-of-range writes while idle.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) write_w(k, $urandom_range(0, 5));
      drive(1'b1, 3'($urandom), 1'b1, 4'($urandom_range(0, 8)), 8'($urandom_range(0, 6)));
      for (int c = 0; c < 12; c++)
        drive(1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      wait_idle();
      drive(1'b0, 3'b000, 1'b1, 4'($urandom_range(9, 15)), 8'hff);
      step(3'($urandom));
    end

    // Back-to-back: start held high.
    for (int c = 0; c < 5 * PERIOD; c++) drive(1'b1, 3'($urandom), 1'b0, 4'd0, 8'd0);
    wait_idle();

    // Free-running random traffic.
    for (int c = 0; c < 600; c++)
      drive(($urandom_range(0, 3) == 0), 3'($urandom), ($urandom_range(0, 4) == 0),
            4'($urandom), ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6)));
    wait_idle();

    // Reset after activity must clear spike_out and membranes.
    do_reset("reset_final");
    step(3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
